// File: rtl/dw02_div_seq.sv
// Sequential restoring radix-2 divider: one quotient bit per clock, with a
// start/complete handshake and optional two's-complement operands.
module dw02_div_seq #(
    parameter int unsigned A_width = 16,
    parameter int unsigned B_width = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               TC,
    input  logic [A_width-1:0] A,
    input  logic [B_width-1:0] B,
    output logic               busy,
    output logic               complete,
    output logic [A_width-1:0] quotient,
    output logic [B_width-1:0] remainder,
    output logic               divide_by_0
);

    localparam int unsigned CW = $clog2(A_width + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Dividend magnitude shifts out of the top while quotient bits shift in.
    logic [A_width-1:0] q_q, q_d;
    logic [B_width:0]   rem_q, rem_d;
    logic [B_width:0]   dmag_q, dmag_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               tc_q, tc_d;
    logic               asign_q, asign_d;
    logic [B_width-1:0] alow_q, alow_d;
    logic               dz_q, dz_d;
    logic               complete_q, complete_d;
    logic [A_width-1:0] quot_q, quot_d;
    logic [B_width-1:0] rout_q, rout_d;
    logic               dbz_q, dbz_d;

    logic [A_width-1:0] a_mag;
    logic [B_width:0]   b_mag;
    logic [B_width+1:0] rem_shift;
    logic [B_width+1:0] diff;

    always_comb begin
        // Unsigned A_width bits hold the magnitude of the most-negative value exactly.
        a_mag     = (TC && A[A_width-1]) ? -A : A;
        b_mag     = {1'b0, ((TC && B[B_width-1]) ? -B : B)};
        rem_shift = {rem_q, q_q[A_width-1]};
        diff      = rem_shift - {1'b0, dmag_q};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        rem_d      = rem_q;
        dmag_d     = dmag_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        tc_d       = tc_q;
        asign_d    = asign_q;
        alow_d     = alow_q;
        dz_d       = dz_q;
        complete_d = complete_q;
        quot_d     = quot_q;
        rout_d     = rout_q;
        dbz_d      = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StCalc;
                    cnt_d      = CW'(A_width);
                    q_d        = a_mag;
                    rem_d      = '0;
                    dmag_d     = b_mag;
                    qneg_d     = TC & (A[A_width-1] ^ B[B_width-1]);
                    rneg_d     = TC & A[A_width-1];
                    tc_d       = TC;
                    asign_d    = A[A_width-1];
                    alow_d     = A[B_width-1:0];
                    dz_d       = (B == '0);
                    complete_d = 1'b0;
                    dbz_d      = 1'b0;
                end
            end
            StCalc: begin
                if (!diff[B_width+1]) begin
                    rem_d = diff[B_width:0];
                    q_d   = {q_q[A_width-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[B_width:0];
                    q_d   = {q_q[A_width-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d    = StIdle;
                complete_d = 1'b1;
                dbz_d      = dz_q;
                if (dz_q) begin
                    if (!tc_q) begin
                        quot_d = '1;
                    end else if (asign_q) begin
                        quot_d = {1'b1, {(A_width - 1){1'b0}}};
                    end else begin
                        quot_d = {1'b0, {(A_width - 1){1'b1}}};
                    end
                    rout_d = alow_q;
                end else begin
                    quot_d = qneg_q ? -q_q : q_q;
                    rout_d = rneg_q ? -rem_q[B_width-1:0] : rem_q[B_width-1:0];
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            dmag_q     <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            tc_q       <= 1'b0;
            asign_q    <= 1'b0;
            alow_q     <= '0;
            dz_q       <= 1'b0;
            complete_q <= 1'b0;
            quot_q     <= '0;
            rout_q     <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            dmag_q     <= dmag_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            tc_q       <= tc_d;
            asign_q    <= asign_d;
            alow_q     <= alow_d;
            dz_q       <= dz_d;
            complete_q <= complete_d;
            quot_q     <= quot_d;
            rout_q     <= rout_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign complete    = complete_q;
    assign quotient    = quot_q;
    assign remainder   = rout_q;
    assign divide_by_0 = dbz_q;

endmodule

// File: tb/tb_dw02_div_seq.sv
// Self-checking bench for dw02_div_seq (8/8 bit): directed cases, handshake
// corners, reset abort and random operands against an integer-division model.
module tb_dw02_div_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       TC = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       busy, complete, divide_by_0;
    logic [7:0] quotient, remainder;

    int n_checks = 0;
    int n_pass   = 0;

    dw02_div_seq #(.A_width(8), .B_width(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .TC         (TC),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .complete   (complete),
        .quotient   (quotient),
        .remainder  (remainder),
        .divide_by_0(divide_by_0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: truncating integer division, remainder takes the dividend's sign.
    task automatic model(input bit tc, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic dz);
        int ia, ib;
        ia = tc ? int'($signed(a)) : int'(a);
        ib = tc ? int'($signed(b)) : int'(b);
        if (ib == 0) begin
            dz = 1'b1;
            r  = a;
            if (!tc) q = 8'hFF;
            else q = (ia < 0) ? 8'h80 : 8'h7F;
        end else begin
            dz = 1'b0;
            q  = 8'(ia / ib);
            r  = 8'(ia % ib);
        end
    endtask

    task automatic check_result(input string tag, input bit tc, input logic [7:0] a,
                                input logic [7:0] b);
        logic [7:0] eq, er;
        logic       ed;
        model(tc, a, b, eq, er, ed);
        check({tag, " complete"}, 32'(complete), 32'd1);
        check({tag, " Q"}, 32'(quotient), 32'(eq));
        check({tag, " R"}, 32'(remainder), 32'(er));
        check({tag, " dz"}, 32'(divide_by_0), 32'(ed));
    endtask

    // One operation from idle; operands are scrambled after capture.
    task automatic do_op(input string tag, input bit tc, input logic [7:0] a,
                         input logic [7:0] b);
        int  cyc;
        bit  cmp_low;
        @(negedge clk);
        start = 1'b1; TC = tc; A = a; B = b;
        @(negedge clk);
        start = 1'b0; TC = 1'($urandom); A = 8'($urandom); B = 8'($urandom);
        cyc = 0;
        cmp_low = 1'b1;
        while (busy && cyc < 50) begin
            if (complete) cmp_low = 1'b0;
            cyc++;
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 32'(cyc), 32'd9);
        check({tag, " complete low while busy"}, 32'(cmp_low), 32'd1);
        check_result(tag, tc, a, b);
    endtask

    initial begin
        int cyc;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset complete", 32'(complete), 32'd0);
        check("reset Q", 32'(quotient), 32'd0);
        check("reset R", 32'(remainder), 32'd0);
        check("reset dz", 32'(divide_by_0), 32'd0);
        rst_n = 1'b1;

        do_op("unsigned basic", 1'b0, 8'd200, 8'd7);
        do_op("signed neg A", 1'b1, 8'h9C, 8'd7);
        do_op("signed neg B", 1'b1, 8'd100, 8'hF9);
        do_op("div0 unsigned", 1'b0, 8'h55, 8'h00);
        do_op("div0 signed", 1'b1, 8'h85, 8'h00);
        do_op("div0 signed pos", 1'b1, 8'h35, 8'h00);
        do_op("signed overflow", 1'b1, 8'h80, 8'hFF);
        do_op("max by one", 1'b0, 8'd255, 8'd1);
        do_op("small by large", 1'b0, 8'd3, 8'd200);

        // Start pulse with new operands mid-operation must be ignored.
        @(negedge clk);
        start = 1'b1; TC = 1'b0; A = 8'd200; B = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; A = 8'd1; B = 8'd1; TC = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!complete && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check("ignored start wait", 32'(cyc), 32'd6);
        check_result("ignored start", 1'b0, 8'd200, 8'd7);
        @(negedge clk);
        check("ignored start idle", 32'(busy), 32'd0);

        // Back-to-back issue with start held high.
        @(negedge clk);
        start = 1'b1; TC = 1'b0; A = 8'd100; B = 8'd9;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] ca, cb;
            bit         ctc;
            ca = A; cb = B; ctc = TC;
            cyc = 0;
            while (!complete && cyc < 50) begin
                cyc++;
                @(negedge clk);
            end
            check("b2b complete low cycles", 32'(cyc), 32'd9);
            check_result("b2b", ctc, ca, cb);
            if (i == 2) start = 1'b0;
            TC = 1'b1; A = 8'($urandom); B = 8'($urandom_range(1, 255));
            @(negedge clk);
        end
        check("b2b stop", 32'(busy), 32'd0);

        // Asynchronous reset four cycles into CALC.
        @(negedge clk);
        start = 1'b1; TC = 1'b0; A = 8'd77; B = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort complete", 32'(complete), 32'd0);
        check("abort Q", 32'(quotient), 32'd0);
        check("abort R", 32'(remainder), 32'd0);
        check("abort dz", 32'(divide_by_0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after reset", 1'b0, 8'd50, 8'd5);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            do_op("random", 1'($urandom), ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
